// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch (I) and data (D) ports onto the single-ported memory with registered responses
// Define ARB_FAIR_EN to force an I grant after STARVE_LIMIT consecutive denied cycles; otherwise D has strict priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [15:0]           i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [15:0]           d_rdata,
  output logic                  d_err,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out
);
  logic fair;
  logic [ADDR_WIDTH-1:0] sel_addr;
`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt;
  assign fair = cnt == CW'(STARVE_LIMIT) && i_req && d_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (i_req && !i_gnt) cnt <= cnt == CW'(STARVE_LIMIT) ? cnt : cnt + 1'b1;
    else cnt <= '0;
`else
  logic unused_limit;
  assign fair = 1'b0;
  assign unused_limit = |STARVE_LIMIT;
`endif
  always_comb begin
    d_gnt = d_req && !rst && !fair;
    i_gnt = i_req && !rst && !d_gnt;
    sel_addr = d_gnt ? d_addr : i_addr;
    mem_enable = (i_gnt || d_gnt) && !sel_addr[0];
    mem_wr = d_gnt && d_wr && !d_addr[0];
    mem_addr = (i_gnt || d_gnt) ? sel_addr : '0;
    mem_data_in = d_gnt ? d_wdata : '0;
  end
  // misaligned grants consume the request but only raise err; memory is never enabled for them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i_rvalid <= 1'b0;
      i_err <= 1'b0;
      i_rdata <= '0;
      d_rvalid <= 1'b0;
      d_err <= 1'b0;
      d_rdata <= '0;
    end else begin
      i_rvalid <= i_gnt && !i_addr[0];
      i_err <= i_gnt && i_addr[0];
      if (i_gnt && !i_addr[0]) i_rdata <= mem_data_out;
      d_rvalid <= d_gnt && !d_wr && !d_addr[0];
      d_err <= d_gnt && d_addr[0];
      if (d_gnt && !d_wr && !d_addr[0]) d_rdata <= mem_data_out;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus reset and starvation sequences against a behavioural memory
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_enable, mem_wr;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
  logic [15:0] mem [256];
  int total = 0, bad = 0;

  mem_arbiter #(.ADDR_WIDTH(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out));

  always #5 clk = ~clk;
  assign mem_data_out = mem[mem_addr[8:1]];
  always @(posedge clk) if (mem_enable && mem_wr) mem[mem_addr[8:1]] <= mem_data_in;

  typedef struct {
    logic ir; logic [15:0] ia;
    logic dr, dw; logic [15:0] da, dd;
    logic eig, edg, een, ewr; logic [15:0] eaddr, edin;
    logic eirv, eierr; logic [15:0] eird;
    logic edrv, ederr; logic [15:0] edrd;
  } vec_t;
  vec_t v [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd);
    i_req = ir; i_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dd;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[3] = 16'h3333; mem[8] = 16'hBEEF;
    v[0] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 16'h0000};
    v[1] = '{0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 0, 1, 1, 1, 16'h0020, 16'h1234, 0, 0, 16'hBEEF, 0, 0, 16'h0000};
    v[2] = '{0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 0, 1, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 16'h1234};
    v[3] = '{1, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1, 1, 0, 16'h0002, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 16'h2222};
    v[4] = '{1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h1111, 0, 0, 16'h2222};
    v[5] = '{0, 16'h0000, 1, 0, 16'h0005, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h1111, 0, 1, 16'h2222};
    v[6] = '{0, 16'h0000, 1, 1, 16'h0007, 16'hDEAD, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h1111, 0, 1, 16'h2222};
    v[7] = '{1, 16'h0011, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1111, 0, 0, 16'h2222};
    v[8] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h1111, 0, 0, 16'h2222};
    v[9] = '{0, 16'h0000, 1, 0, 16'h0006, 16'h0000, 0, 1, 1, 0, 16'h0006, 16'h0000, 0, 0, 16'h1111, 1, 0, 16'h3333};
    drive(1, 16'h0010, 1, 1, 16'h0020, 16'hAAAA);
    #1;
    chk("rst_i_gnt", i_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_enable", mem_enable, 0); chk("rst_mem_wr", mem_wr, 0);
    chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_err", i_err, 0); chk("rst_d_err", d_err, 0);
    chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      drive(v[n].ir, v[n].ia, v[n].dr, v[n].dw, v[n].da, v[n].dd);
      #1;
      chk($sformatf("v%0d_i_gnt", n), i_gnt, v[n].eig);
      chk($sformatf("v%0d_d_gnt", n), d_gnt, v[n].edg);
      chk($sformatf("v%0d_mem_enable", n), mem_enable, v[n].een);
      chk($sformatf("v%0d_mem_wr", n), mem_wr, v[n].ewr);
      if (v[n].een || !(v[n].eig || v[n].edg)) chk($sformatf("v%0d_mem_addr", n), mem_addr, v[n].eaddr);
      if (v[n].ewr || !(v[n].eig || v[n].edg)) chk($sformatf("v%0d_mem_data_in", n), mem_data_in, v[n].edin);
      @(posedge clk); #1;
      chk($sformatf("v%0d_i_rvalid", n), i_rvalid, v[n].eirv);
      chk($sformatf("v%0d_i_err", n), i_err, v[n].eierr);
      chk($sformatf("v%0d_i_rdata", n), i_rdata, v[n].eird);
      chk($sformatf("v%0d_d_rvalid", n), d_rvalid, v[n].edrv);
      chk($sformatf("v%0d_d_err", n), d_err, v[n].ederr);
      chk($sformatf("v%0d_d_rdata", n), d_rdata, v[n].edrd);
    end
    // reset while an I read response is pending
    @(negedge clk);
    drive(1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
    #1 chk("inflight_i_gnt", i_gnt, 1);
    @(posedge clk); #1;
    chk("inflight_i_rvalid", i_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_i_rvalid", i_rvalid, 0); chk("midrst_i_rdata", i_rdata, 0);
    chk("midrst_mem_enable", mem_enable, 0); chk("midrst_i_gnt", i_gnt, 0);
    @(posedge clk); #1;
    chk("midrst_hold_i_rvalid", i_rvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_i_gnt", i_gnt, 1); chk("post_rst_mem_enable", mem_enable, 1);
    @(posedge clk); #1;
    chk("post_rst_i_rvalid", i_rvalid, 1); chk("post_rst_i_rdata", i_rdata, 16'hBEEF);
    // continuous contention: I wins every 5th cycle only with fairness enabled
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1, 16'h0010, 1, 0, 16'h0002, 16'h0000);
      #1;
`ifdef ARB_FAIR_EN
      chk($sformatf("fair%0d_i_gnt", k), i_gnt, (k % 5) == 4);
      chk($sformatf("fair%0d_d_gnt", k), d_gnt, (k % 5) != 4);
`else
      chk($sformatf("fair%0d_i_gnt", k), i_gnt, 0);
      chk($sformatf("fair%0d_d_gnt", k), d_gnt, 1);
`endif
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
